cpa_arbiter: RTL and testbench

Round-robin scheduler that shares one registered carry-propagate adder (add/subtract, signed overflow) between `NREQ` requesters. Each requester presents operands with a valid/ready handshake. The block grants one request per cycle, computes the sum through a single adder instance, and returns the result with the requester's ID on a registered response port with backpressure. It sits between the operand-producing blocks and the shared CPA datapath.

---
 rtl/cpa_pkg.sv | 39 +++
 rtl/cpa_core.sv | 39 +++
 rtl/cpa_arbiter.sv | 130 +++++++++++++
 tb/tb_cpa_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cpa_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : cpa_pkg                                                |
// | Description : Shared types, defaults and the round-robin pick helper |
// |               for the shared carry-propagate adder arbiter.          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package cpa_pkg;

  localparam int CPA_WIDTH = 13;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Returns the first index with valid set, searching upward from last+1
  // and wrapping modulo nreq. Callers qualify the result with |valid.
  function automatic int unsigned rr_pick(input logic [31:0] valid,
                                          input int unsigned last,
                                          input int unsigned nreq);
    int unsigned pick;
    int unsigned idx;
    logic        found;
    pick  = 0;
    idx   = 0;
    found = 1'b0;
    for (int unsigned k = 1; k <= nreq; k++) begin
      idx = (last + k) % nreq;
      if (!found && valid[idx[4:0]]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpa_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : cpa_core                                               |
// | Description : Combinational ripple-carry adder exposing the carry    |
// |               out of the MSB and the carry into the MSB.             |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module cpa_core
  import cpa_pkg::*;
#(
  parameter int WIDTH = CPA_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  // Ripple the carry bit by bit; the carry entering the top bit is captured
  // separately so the caller can form signed overflow.
  always_comb begin : ripple
    logic carry;
    carry = cin;
    sum   = '0;
    c_msb = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i == WIDTH - 1) begin
        c_msb = carry;
      end
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule
`default_nettype wire

// File: rtl/cpa_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : cpa_arbiter                                            |
// | Description : Round-robin scheduler sharing one registered add/sub   |
// |               datapath between NREQ requesters, with a registered    |
// |               backpressured response port.                           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module cpa_arbiter
  import cpa_pkg::*;
#(
  parameter int WIDTH = CPA_WIDTH,
  parameter int NREQ  = 2,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_sub,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_cout,
  output logic                  rsp_overflow
);

  state_t           state_q, state_d;
  logic [IDW-1:0]   last_q, last_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             can_accept;
  logic             grant;
  logic [IDW-1:0]   grant_idx;
  logic [WIDTH-1:0] a_sel, b_sel, b_eff;
  logic             sub_sel;
  logic [WIDTH-1:0] core_sum;
  logic             core_cout, core_cmsb;

  // Grant when the output slot is free or being drained this cycle; reset
  // forces the grant off so nothing handshakes while it is asserted.
  assign can_accept = (state_q == IDLE) | rsp_ready;
  assign grant_idx  = IDW'(rr_pick(32'(req_valid), 32'(last_q), NREQ));
  assign grant      = can_accept & (|req_valid) & ~reset;

  for (genvar i = 0; i < NREQ; i++) begin : g_ready
    assign req_ready[i] = grant & (grant_idx == IDW'(i));
  end

  // Operand mux for the granted requester.
  always_comb begin
    a_sel   = '0;
    b_sel   = '0;
    sub_sel = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        a_sel   = req_a[i*WIDTH +: WIDTH];
        b_sel   = req_b[i*WIDTH +: WIDTH];
        sub_sel = req_sub[i];
      end
    end
  end

  // Subtraction as A + ~B + 1.
  assign b_eff = sub_sel ? ~b_sel : b_sel;

  cpa_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a     (a_sel),
    .b     (b_eff),
    .cin   (sub_sel),
    .sum   (core_sum),
    .cout  (core_cout),
    .c_msb (core_cmsb)
  );

  // Next-state: a grant loads a fresh result; a drain with no grant empties.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (grant) begin
      state_d = HOLD;
      last_d  = grant_idx;
      id_d    = grant_idx;
      sum_d   = core_sum;
      cout_d  = core_cout;
      ovf_d   = core_cmsb ^ core_cout;
    end else if ((state_q == HOLD) && rsp_ready) begin
      state_d = IDLE;
    end
  end

  // State and response registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= IDW'(NREQ - 1);
      id_q    <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign rsp_valid    = (state_q == HOLD);
  assign rsp_id       = id_q;
  assign rsp_sum      = sum_q;
  assign rsp_cout     = cout_q;
  assign rsp_overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_cpa_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_cpa_arbiter                                         |
// | Description : Directed self-checking bench for cpa_arbiter.          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_cpa_arbiter;

  localparam int WIDTH = 13;
  localparam int NREQ  = 2;
  localparam int IDW   = 1;

  logic                  clk;
  logic                  reset;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_sub;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_cout;
  logic                  rsp_overflow;

  int checks;
  int errors;

  cpa_arbiter #(
    .WIDTH (WIDTH),
    .NREQ  (NREQ),
    .IDW   (IDW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_sub      (req_sub),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_sum      (rsp_sum),
    .rsp_cout     (rsp_cout),
    .rsp_overflow (rsp_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic s);
    req_valid[i]              = v;
    req_a[i*WIDTH +: WIDTH]   = a;
    req_b[i*WIDTH +: WIDTH]   = b;
    req_sub[i]                = s;
  endtask

  task automatic chk_ready(input string name, input logic [NREQ-1:0] exp);
    checks++;
    if (req_ready !== exp) begin
      errors++;
      $display("FAIL %s req_ready got=%b exp=%b", name, req_ready, exp);
    end
  endtask

  task automatic chk_rsp(input string name, input logic v, input logic [IDW-1:0] id,
                         input logic [WIDTH-1:0] s, input logic c, input logic o);
    checks++;
    if ({rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_overflow} !== {v, id, s, c, o}) begin
      errors++;
      $display("FAIL %s rsp got v=%b id=%0d sum=%h c=%b o=%b exp v=%b id=%0d sum=%h c=%b o=%b",
               name, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_overflow, v, id, s, c, o);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_sub   = '0;
    rsp_ready = 1'b1;
    tick();
    set_req(0, 1'b1, 13'h0001, 13'h0001, 1'b0);
    #1;
    chk_ready("reset_ready_held", 2'b00);
    req_valid = '0;
    tick();
    reset = 1'b0;
    tick();
    chk_ready("idle_ready", 2'b00);
    chk_rsp("reset_rsp", 1'b0, 1'b0, 13'h0000, 1'b0, 1'b0);
  endtask

  task automatic test_add();
    set_req(0, 1'b1, 13'h0FFF, 13'h0001, 1'b0);
    #1;
    chk_ready("add_grant", 2'b01);
    tick();
    req_valid = '0;
    chk_rsp("add_result", 1'b1, 1'b0, 13'h1000, 1'b0, 1'b1);
    tick();
    chk_rsp("add_drain", 1'b0, 1'b0, 13'h1000, 1'b0, 1'b1);
  endtask

  task automatic test_sub();
    set_req(1, 1'b1, 13'd5, 13'd7, 1'b1);
    #1;
    chk_ready("sub_grant", 2'b10);
    tick();
    chk_rsp("sub_5m7", 1'b1, 1'b1, 13'h1FFE, 1'b0, 1'b0);
    set_req(1, 1'b1, 13'd7, 13'd5, 1'b1);
    #1;
    chk_ready("sub_b2b_grant", 2'b10);
    tick();
    req_valid = '0;
    chk_rsp("sub_7m5", 1'b1, 1'b1, 13'h0002, 1'b1, 1'b0);
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL sub_drain rsp_valid got=%b exp=0", rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [NREQ-1:0]  exp_rdy [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [IDW-1:0]   exp_id  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [WIDTH-1:0] exp_sum [4] = '{13'd11, 13'd22, 13'd11, 13'd22};
    set_req(0, 1'b1, 13'd10, 13'd1, 1'b0);
    set_req(1, 1'b1, 13'd20, 13'd2, 1'b0);
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk_ready($sformatf("rr_grant%0d", k), exp_rdy[k]);
      tick();
      chk_rsp($sformatf("rr_rsp%0d", k), 1'b1, exp_id[k], exp_sum[k], 1'b0, 1'b0);
    end
  endtask

  task automatic test_backpressure();
    req_valid[0] = 1'b0;
    set_req(1, 1'b1, 13'd100, 13'd1, 1'b1);
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk_ready($sformatf("bp_stall_ready%0d", k), 2'b00);
      tick();
      chk_rsp($sformatf("bp_stall_rsp%0d", k), 1'b1, 1'b1, 13'd22, 1'b0, 1'b0);
    end
    rsp_ready = 1'b1;
    #1;
    chk_ready("bp_release_grant", 2'b10);
    tick();
    req_valid = '0;
    chk_rsp("bp_result", 1'b1, 1'b1, 13'h0063, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_async_reset();
    set_req(0, 1'b1, 13'd1, 13'd1, 1'b0);
    rsp_ready = 1'b1;
    tick();
    req_valid = '0;
    rsp_ready = 1'b0;
    chk_rsp("ar_hold", 1'b1, 1'b0, 13'd2, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk_rsp("ar_async_clear", 1'b0, 1'b0, 13'd0, 1'b0, 1'b0);
    tick();
    set_req(0, 1'b1, 13'd3, 13'd4, 1'b0);
    set_req(1, 1'b1, 13'd9, 13'd9, 1'b0);
    reset = 1'b0;
    rsp_ready = 1'b1;
    #1;
    chk_ready("ar_first_grant", 2'b01);
    tick();
    req_valid[0] = 1'b0;
    chk_rsp("ar_first_rsp", 1'b1, 1'b0, 13'd7, 1'b0, 1'b0);
    #1;
    chk_ready("ar_second_grant", 2'b10);
    tick();
    req_valid = '0;
    chk_rsp("ar_second_rsp", 1'b1, 1'b1, 13'd18, 1'b0, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_backpressure();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
